arb_weighted_round_robin: RTL and testbench
===========================================

// Module: arb_weighted_round_robin
// PURPOSE
//   Parametrised weighted round-robin arbiter with a yumi (accept) handshake.
//   Each requester that wins arbitration keeps the grant for a programmable
//   number of consecutive accepted grants (its weight). Ownership then passes
//   round-robin to the next active requester.
//   Sits in front of shared resources (memory ports, NoC links) that need
//   bandwidth shares that are unequal but starvation-free.
// PARAMETERS
//   NUM_REQ   4  number of requesters; legal values are 2..32
//   WEIGHT_W  4  width of each per-requester weight field
//   ID_W      $clog2(NUM_REQ)  width of grant_id_o (derived; do not override)
// PORTS
//   clk_i       in   1                 clock
//   reset_i     in   1                 reset, asynchronous, active-high
//   reqs_i      in   NUM_REQ           request vector; bit i = requester i
//   weights_i   in   NUM_REQ*WEIGHT_W  weight of requester i in bits [i*WEIGHT_W +: WEIGHT_W]
//   grants_o    out  NUM_REQ           one-hot grant, combinational from state and reqs_i
//   grant_id_o  out  ID_W              index of the granted requester; 0 when v_o=0
//   v_o         out  1                 asserted when any grant is issued (equals |reqs_i)
//   yumi_i      in   1                 consumer accepts the current grant; legal only when v_o=1
// BEHAVIOUR
//   Clock and reset: reset reset_i, asynchronous, active-high; clock clk_i.
//   State registers:
//     owner_r  ID_W bits; resets to NUM_REQ-1, so the first search starts at requester 0.
//     credit_r WEIGHT_W bits; resets to 0. Holds the grants remaining to owner_r after the current one.
//   Effective weight: ew(i) = (weights_i[i]==0) ? 1 : weights_i[i]. A weight of 0 counts as 1.
//   Combinational arbitration:
//     Sticky case (credit_r!=0 and reqs_i[owner_r]=1): winner = owner_r.
//     Otherwise: winner = first set bit of reqs_i searching owner_r+1, owner_r+2, ...,
//       wrapping modulo NUM_REQ. owner_r itself is checked last.
//     reqs_i==0: grants_o=0, v_o=0, grant_id_o=0.
//   Outputs:
//     grants_o is always one-hot or all-zero.
//     A grant is never given to a requester whose reqs_i bit is 0.
//   Update on the clock edge, only when yumi_i & v_o:
//     winner==owner_r in the sticky case: credit_r <= credit_r-1.
//     New turn (any other case, including owner re-winning after its credit expired):
//       owner_r <= winner; credit_r <= ew(winner)-1.
//   No update when yumi_i=0:
//     State holds.
//     grants_o may change if reqs_i changes; grants are not locked before accept.
//   Weight sampling: weights_i is sampled only at the start of a turn.
//     A change during a burst takes effect at that requester's next turn.
//   Dropped owner: if reqs_i[owner_r] falls while credit_r!=0, the remaining credit is forfeited.
//     The next accept starts a new turn from owner_r+1.
//   Single active requester: it wins every cycle, and its turns restart back-to-back.
//   Fairness bound: a requester held high is granted within
//     sum over other requesters j of ew(j) accepted grants.
//   reset_i mid-burst: state returns to reset values immediately (asynchronous).
//     Outputs re-evaluate combinationally with search from requester 0.
//   yumi_i while v_o=0 is ignored. This is flagged by an assertion.
// TESTING
//   1. Reset, reqs=4'b1111, weights all 1, yumi=1
//      -> grants cycle 0001,0010,0100,1000,0001; strict round robin.
//   2. reqs=4'b0011, weights {w0=3,w1=1}, yumi=1
//      -> grant ids 0,0,0,1,0,0,0,1; w0 burst restarts after 1.
//   3. reqs=4'b0101, w0=4; drop req0 after 2 accepts
//      -> next grant to 2 with credit forfeited; req0 re-raised resumes after 2's turn.
//   4. reqs=4'b1111, yumi=0 for 5 cycles, then 1
//      -> grant holds 0001 with no state change; accepts then proceed 0001,0010...
//   5. weights=0 for all, reqs=4'b1001
//      -> grants alternate 0001,1000 (weight 0 treated as 1).
//   6. Mid-burst (owner=1, credit=2) assert reset_i for 1 cycle with reqs=4'b1110
//      -> grants_o=0010 immediately (search from 0); credit_r=0.
//   Formal: onehot0(grants_o); grants_o & ~reqs_i == 0; fairness bound per requester; v_o == |reqs_i.

Source files
------------

// File: rtl/arb_weighted_round_robin.sv
// rtl/arb_weighted_round_robin.sv - weighted round-robin arbiter with yumi accept handshake
// The current owner keeps the grant for ew(owner) accepts; ownership then rotates to the next active requester.
module arb_weighted_round_robin #(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ-1:0]           reqs_i,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weights_i,
  output logic [NUM_REQ-1:0]           grants_o,
  output logic [ID_W-1:0]              grant_id_o,
  output logic                         v_o,
  input  logic                         yumi_i
);

  logic [ID_W-1:0]     owner_q, owner_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic                sticky;
  logic                found;
  logic [ID_W-1:0]     search_id;
  logic [ID_W-1:0]     winner_id;
  logic [WEIGHT_W-1:0] w_sel;
  logic [WEIGHT_W-1:0] ew_m1;

  // Rotating search starts just after the owner, so the owner itself is considered last.
  always_comb begin
    found     = 1'b0;
    search_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = int'(owner_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && reqs_i[idx]) begin
        found     = 1'b1;
        search_id = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sticky     = (credit_q != '0) && reqs_i[owner_q];
    winner_id  = sticky ? owner_q : search_id;
    v_o        = |reqs_i;
    grant_id_o = v_o ? winner_id : '0;
    grants_o   = v_o ? (NUM_REQ'(1) << winner_id) : '0;

    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == winner_id) w_sel = weights_i[i*WEIGHT_W +: WEIGHT_W];
    end
    // A zero weight behaves as one, so the turn has no remaining credit.
    ew_m1 = (w_sel == '0) ? '0 : w_sel - WEIGHT_W'(1);
  end

  always_comb begin
    owner_d  = owner_q;
    credit_d = credit_q;
    if (yumi_i && v_o) begin
      if (sticky) begin
        credit_d = credit_q - WEIGHT_W'(1);
      end else begin
        owner_d  = winner_id;
        credit_d = ew_m1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      owner_q  <= ID_W'(NUM_REQ - 1);
      credit_q <= '0;
    end else begin
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));
  a_grant_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(grants_o) && ((grants_o & ~reqs_i) == '0) && (v_o == |reqs_i));

endmodule

// File: tb/tb_arb_weighted_round_robin.sv
// tb/tb_arb_weighted_round_robin.sv - directed self-checking bench for arb_weighted_round_robin
module tb_arb_weighted_round_robin;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  reqs_i = '0;
  logic [15:0] weights_i = '0;
  logic [3:0]  grants_o;
  logic [1:0]  grant_id_o;
  logic        v_o;
  logic        yumi_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  arb_weighted_round_robin #(.NUM_REQ(4), .WEIGHT_W(4)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .reqs_i     (reqs_i),
    .weights_i  (weights_i),
    .grants_o   (grants_o),
    .grant_id_o (grant_id_o),
    .v_o        (v_o),
    .yumi_i     (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  // Check the combinational grant, then let one clock edge apply it.
  task automatic expect_g(input string tag, input logic [3:0] exp_g);
    #1;
    chk(tag, 32'(grants_o), 32'(exp_g));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // 1: strict round robin with unit weights
    reqs_i = 4'b1111; weights_i = 16'h1111; yumi_i = 1'b1;
    do_reset();
    #1;
    chk("t1_rst_owner", 32'(dut.owner_q), 32'd3);
    chk("t1_rst_credit", 32'(dut.credit_q), 32'd0);
    expect_g("t1_g0", 4'b0001);
    expect_g("t1_g1", 4'b0010);
    expect_g("t1_g2", 4'b0100);
    expect_g("t1_g3", 4'b1000);
    expect_g("t1_g4", 4'b0001);

    // 2: w0=3, w1=1 -> ids 0,0,0,1,0,0,0,1
    reqs_i = 4'b0011; weights_i = 16'h0013; yumi_i = 1'b1;
    do_reset();
    begin
      logic [1:0] ids [8];
      ids = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
      for (int i = 0; i < 8; i++) begin
        #1;
        chk($sformatf("t2_id%0d", i), 32'(grant_id_o), 32'(ids[i]));
        @(posedge clk_i);
        #1;
      end
    end

    // 3: owner 0 dropped mid-burst forfeits its credit
    reqs_i = 4'b0101; weights_i = 16'h0104; yumi_i = 1'b1;
    do_reset();
    expect_g("t3_a0", 4'b0001);
    expect_g("t3_a1", 4'b0001);
    reqs_i = 4'b0100;
    #1;
    chk("t3_drop_id", 32'(grant_id_o), 32'd2);
    expect_g("t3_drop_g", 4'b0100);
    reqs_i = 4'b0101;
    expect_g("t3_resume", 4'b0001);
    chk("t3_credit", 32'(dut.credit_q), 32'd3);

    // 4: no accept holds state; accepts then proceed
    reqs_i = 4'b1111; weights_i = 16'h1111; yumi_i = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) expect_g($sformatf("t4_hold%0d", i), 4'b0001);
    chk("t4_owner_held", 32'(dut.owner_q), 32'd3);
    yumi_i = 1'b1;
    expect_g("t4_acc0", 4'b0001);
    expect_g("t4_acc1", 4'b0010);
    expect_g("t4_acc2", 4'b0100);

    // 5: zero weights act as one
    reqs_i = 4'b1001; weights_i = 16'h0000; yumi_i = 1'b1;
    do_reset();
    expect_g("t5_g0", 4'b0001);
    expect_g("t5_g1", 4'b1000);
    expect_g("t5_g2", 4'b0001);
    expect_g("t5_g3", 4'b1000);

    // Idle: no requests means no grant
    yumi_i = 1'b0; reqs_i = 4'b0000;
    #1;
    chk("idle_g", 32'(grants_o), 32'd0);
    chk("idle_v", 32'(v_o), 32'd0);
    chk("idle_id", 32'(grant_id_o), 32'd0);
    reqs_i = 4'b0100;
    #1;
    chk("single_v", 32'(v_o), 32'd1);

    // 6: asynchronous reset mid-burst
    reqs_i = 4'b1110; weights_i = 16'h0030; yumi_i = 1'b1;
    do_reset();
    expect_g("t6_first", 4'b0010);
    chk("t6_credit_mid", 32'(dut.credit_q), 32'd2);
    #2;
    yumi_i = 1'b0;
    reset_i = 1'b1;
    #1;
    chk("t6_async_credit", 32'(dut.credit_q), 32'd0);
    chk("t6_async_owner", 32'(dut.owner_q), 32'd3);
    chk("t6_async_g", 32'(grants_o), 32'b0010);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    yumi_i = 1'b1;
    expect_g("t6_after", 4'b0010);
    chk("t6_new_credit", 32'(dut.credit_q), 32'd2);
    yumi_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
